// File: rtl/serial_pkg.sv
// Shared definitions for the dumb-serial frame transmitter: parity modes,
// FSM state encoding and the frame-length helper.
package serial_pkg;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StGap
    } state_e;

    // Bits on the wire per frame: data plus an optional trailing parity bit.
    function automatic int unsigned frame_bits(int unsigned width, int unsigned parity);
        return width + ((parity != PARITY_NONE) ? 1 : 0);
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// Half-period timer: pulses tick on the last clock of every DIV-clock phase
// while enabled. Restart forces the count back to the start of a phase.
module serial_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clock,
    input  logic resetN,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = enable && (cnt_q == CNT_W'(DIV - 1));

    // Next count: wrap on tick, hold while disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (restart) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_frame_tx.sv
// Frame transmitter: one-word holding buffer feeding a shift register that is
// clocked out on a source-synchronous serialClock/serialData pair, framed by
// serialFrame and followed by a fixed idle gap.
module serial_frame_tx
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned DIV       = 1,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP       = 2
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [WIDTH-1:0] inData,
    input  logic             inValid,
    output logic             inReady,
    output logic             serialClock,
    output logic             serialData,
    output logic             serialFrame,
    output logic             busy,
    output logic             frameDone
);

    localparam int unsigned N     = frame_bits(WIDTH, PARITY);
    localparam int unsigned BIT_W = $clog2(N + 1);
    localparam int unsigned GAP_W = $clog2(GAP + 1);

    state_e state_q, state_d;

    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic [N-1:0]     shifted;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;

    logic sclk_q, sclk_d;
    logic sdata_q, sdata_d;
    logic frame_q, frame_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    logic             accept, load, tick, last_bit, bit_end, frame_end, gap_end;
    logic [WIDTH-1:0] ordered;
    logic             par_bit;
    logic [N-1:0]     frame_word;

    assign inReady   = !buf_full_q && resetN;
    assign accept    = inValid && inReady;
    assign load      = (state_q == StIdle) && buf_full_q;
    assign last_bit  = (bit_cnt_q == BIT_W'(N - 1));
    // A bit ends on the tick that closes its high phase.
    assign bit_end   = (state_q == StShift) && tick && sclk_q;
    assign frame_end = bit_end && last_bit;
    assign gap_end   = (state_q == StGap) && (gap_cnt_q == GAP_W'(GAP - 1));
    assign shifted   = shreg_q << 1;

    serial_tick_gen #(
        .DIV(DIV)
    ) u_tick_gen (
        .clock  (clock),
        .resetN (resetN),
        .restart(load),
        .enable (state_q == StShift),
        .tick   (tick)
    );

    // Arrange the buffered word so the first bit on the wire sits at the top.
    always_comb begin
        ordered = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            ordered[i] = (MSB_FIRST != 0) ? buf_q[i] : buf_q[WIDTH - 1 - i];
        end
        par_bit = (PARITY == PARITY_ODD) ? ~^buf_q : ^buf_q;
    end

    if (PARITY == PARITY_NONE) begin : g_no_parity
        assign frame_word = ordered;
    end else begin : g_parity
        assign frame_word = {ordered, par_bit};
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (load) state_d = StShift;
            StShift: if (frame_end) state_d = StGap;
            StGap:   if (gap_end) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values for the registered link outputs.
    always_comb begin
        sclk_d  = 1'b0;
        sdata_d = 1'b0;
        frame_d = (state_d == StShift);
        done_d  = frame_end;
        busy_d  = (state_d != StIdle) || buf_full_d;
        unique case (state_q)
            StIdle: begin
                if (load) sdata_d = frame_word[N-1];
            end
            StShift: begin
                if (!frame_end) begin
                    sclk_d  = tick ? !sclk_q : sclk_q;
                    // Data moves only on the edge that drops serialClock.
                    sdata_d = bit_end ? shifted[N-1] : sdata_q;
                end
            end
            default: begin
                sclk_d  = 1'b0;
                sdata_d = 1'b0;
            end
        endcase
    end

    // Next values for buffer, shift register and counters.
    always_comb begin
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        gap_cnt_d  = (state_q == StGap) ? gap_cnt_q + GAP_W'(1) : '0;
        if (accept) begin
            buf_d      = inData;
            buf_full_d = 1'b1;
        end
        if (load) begin
            buf_full_d = 1'b0;
            shreg_d    = frame_word;
            bit_cnt_d  = '0;
        end
        if (bit_end && !last_bit) begin
            shreg_d   = shifted;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
        end
    end

    // Datapath and output registers; reset truncates any frame and drops the buffer.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            sclk_q     <= 1'b0;
            sdata_q    <= 1'b0;
            frame_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sclk_q     <= sclk_d;
            sdata_q    <= sdata_d;
            frame_q    <= frame_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign serialClock = sclk_q;
    assign serialData  = sdata_q;
    assign serialFrame = frame_q;
    assign busy        = busy_q;
    assign frameDone   = done_q;

endmodule
